// File: rtl/rx_4b5b_decode.sv
// Purpose : receive 12-bit 4B5B-encoded serial frames, decode to a byte, flag
//           symbol/framing/overrun errors, show the byte on LED, resend as 8N1 UART.
// Latency : byte strobed one cycle after the stop-bit sample (N+1); UART start bit at N+2
//           when the transmitter is idle.
// Backpressure: none on the line; one-byte holding register ahead of the UART shifter,
//           a byte arriving while it is full (and not being unloaded) is dropped with err_overrun.
// Ports:
//   CLK_50M, RST       clock, synchronous active-high reset
//   RXD_5B             encoded serial input (async, idle high)
//   RS232_DTE_TXD      8N1 UART output (idle high)
//   LED, data_out      last good byte / decoded byte
//   data_valid, err_code, err_frame, err_overrun   one-cycle strobes
module rx_4b5b_decode #(
  parameter int BIT5_CYCLES = 182,
  parameter int BIT4_CYCLES = 218
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       RXD_5B,
  output logic       RS232_DTE_TXD,
  output logic [7:0] LED,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       err_code,
  output logic       err_frame,
  output logic       err_overrun
);

  localparam int C5W = $clog2(BIT5_CYCLES);
  localparam int C4W = $clog2(BIT4_CYCLES);
  localparam logic [C5W-1:0] RX_HALF = C5W'(BIT5_CYCLES / 2);
  localparam logic [C5W-1:0] RX_LAST = C5W'(BIT5_CYCLES - 1);
  localparam logic [C4W-1:0] TX_LAST = C4W'(BIT4_CYCLES - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // 5B symbol -> {valid, nibble}
  function automatic logic [4:0] dec5(input logic [4:0] c);
    logic [4:0] r;
    r = 5'h00;
    case (c)
      5'b11110: r = {1'b1, 4'h0};
      5'b01001: r = {1'b1, 4'h1};
      5'b10100: r = {1'b1, 4'h2};
      5'b10101: r = {1'b1, 4'h3};
      5'b01010: r = {1'b1, 4'h4};
      5'b01011: r = {1'b1, 4'h5};
      5'b01110: r = {1'b1, 4'h6};
      5'b01111: r = {1'b1, 4'h7};
      5'b10010: r = {1'b1, 4'h8};
      5'b10011: r = {1'b1, 4'h9};
      5'b10110: r = {1'b1, 4'hA};
      5'b10111: r = {1'b1, 4'hB};
      5'b11010: r = {1'b1, 4'hC};
      5'b11011: r = {1'b1, 4'hD};
      5'b11100: r = {1'b1, 4'hE};
      5'b11101: r = {1'b1, 4'hF};
      default:  r = 5'h00;
    endcase
    return r;
  endfunction

  // synchroniser
  logic sync1_q, rs_q;

  // receive side
  rx_state_t        rx_state_q, rx_state_d;
  logic [C5W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [3:0]       rx_bits_q, rx_bits_d;
  logic [9:0]       rx_sh_q, rx_sh_d;

  // outputs and holding register
  logic [7:0] led_q, led_d, dout_q, dout_d, hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       dv_q, dv_d, ec_q, ec_d, ef_q, ef_d, eo_q, eo_d;

  // transmit side
  tx_state_t      tx_state_q, tx_state_d;
  logic [C4W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bits_q, tx_bits_d;
  logic [7:0]     tx_sh_q, tx_sh_d;
  logic           txd_q, txd_d;
  logic           tx_take;

  logic [4:0] dec_lo, dec_hi;
  logic [7:0] dec_byte;
  logic       dec_ok;

  // sample 1 lands in bit 0 after ten right-shifts, so [4:0] is L and [9:5] is H
  assign dec_lo   = dec5(rx_sh_q[4:0]);
  assign dec_hi   = dec5(rx_sh_q[9:5]);
  assign dec_byte = {dec_hi[3:0], dec_lo[3:0]};
  assign dec_ok   = dec_lo[4] & dec_hi[4];

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bits_d   = rx_bits_q;
    rx_sh_d     = rx_sh_q;
    led_d       = led_q;
    dout_d      = dout_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    dv_d        = 1'b0;
    ec_d        = 1'b0;
    ef_d        = 1'b0;
    eo_d        = 1'b0;
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bits_d   = tx_bits_q;
    tx_sh_d     = tx_sh_q;
    txd_d       = txd_q;
    tx_take     = 1'b0;

    // ---------------- transmitter ----------------
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (hold_full_q) tx_take = 1'b1;
      end
      TX_START: begin
        if (tx_cnt_q == TX_LAST) begin
          tx_cnt_d   = '0;
          tx_bits_d  = 3'd0;
          txd_d      = tx_sh_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == TX_LAST) begin
          tx_cnt_d = '0;
          if (tx_bits_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bits_d = tx_bits_q + 1'b1;
            tx_sh_d   = {1'b0, tx_sh_q[7:1]};
            txd_d     = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == TX_LAST) begin
          tx_cnt_d = '0;
          // a waiting byte starts straight after the stop bit, no idle gap
          if (hold_full_q) tx_take = 1'b1;
          else             tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (tx_take) begin
      tx_sh_d     = hold_q;
      hold_full_d = 1'b0;
      txd_d       = 1'b0;
      tx_cnt_d    = '0;
      tx_state_d  = TX_START;
    end

    // ---------------- receiver ----------------
    // Placed after the transmitter so a same-cycle store wins over the unload.
    case (rx_state_q)
      RX_IDLE: begin
        if (!rs_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == RX_HALF) begin
          rx_cnt_d   = '0;
          rx_bits_d  = 4'd0;
          rx_state_d = rs_q ? RX_IDLE : RX_DATA;  // high at mid-start is a glitch
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == RX_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rs_q, rx_sh_q[9:1]};
          if (rx_bits_q == 4'd9) rx_state_d = RX_STOP;
          else                   rx_bits_d  = rx_bits_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == RX_LAST) begin
          rx_cnt_d = '0;
          if (rs_q) begin
            rx_state_d = RX_IDLE;
            if (dec_ok) begin
              dv_d   = 1'b1;
              dout_d = dec_byte;
              led_d  = dec_byte;
              if (hold_full_q && !tx_take) begin
                eo_d = 1'b1;
              end else begin
                hold_d      = dec_byte;
                hold_full_d = 1'b1;
              end
            end else begin
              ec_d = 1'b1;
            end
          end else begin
            ef_d       = 1'b1;
            rx_state_d = RX_WAITHI;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAITHI: begin
        // a line stuck low must not be taken as a run of start bits
        if (rs_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      sync1_q     <= 1'b1;
      rs_q        <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bits_q   <= 4'd0;
      rx_sh_q     <= 10'd0;
      led_q       <= 8'h00;
      dout_q      <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      dv_q        <= 1'b0;
      ec_q        <= 1'b0;
      ef_q        <= 1'b0;
      eo_q        <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bits_q   <= 3'd0;
      tx_sh_q     <= 8'h00;
      txd_q       <= 1'b1;
    end else begin
      sync1_q     <= RXD_5B;
      rs_q        <= sync1_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bits_q   <= rx_bits_d;
      rx_sh_q     <= rx_sh_d;
      led_q       <= led_d;
      dout_q      <= dout_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      dv_q        <= dv_d;
      ec_q        <= ec_d;
      ef_q        <= ef_d;
      eo_q        <= eo_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bits_q   <= tx_bits_d;
      tx_sh_q     <= tx_sh_d;
      txd_q       <= txd_d;
    end
  end

  assign RS232_DTE_TXD = txd_q;
  assign LED           = led_q;
  assign data_out      = dout_q;
  assign data_valid    = dv_q;
  assign err_code      = ec_q;
  assign err_frame     = ef_q;
  assign err_overrun   = eo_q;

endmodule
